// File: rtl/crop_pkg.sv
// Shared pixel types and helpers for the crop / max-pool pipeline.
package crop_pkg;

  localparam int DEF_PIXEL_BIT_WIDTH = 8;
  // Widest pixel the signed_max helper handles; narrower pixels are
  // sign-extended in and truncated back out.
  localparam int MAX_PIXEL_W = 32;

  typedef logic signed [DEF_PIXEL_BIT_WIDTH-1:0] pixel_t;

  // Signed maximum; ties return either operand since they are equal.
  function automatic logic signed [MAX_PIXEL_W-1:0] signed_max(
    input logic signed [MAX_PIXEL_W-1:0] a,
    input logic signed [MAX_PIXEL_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_row_buffer.sv
// One-row partial-max store: COLS/2 entries, one write port, one
// combinational read port, both indexed by col>>1. Not reset; every
// entry is written on an even row before the odd row reads it.
module maxpool_row_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int IW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the even-row pair maximum for this column pair.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 non-overlapping signed max-pool over a raster pixel
// stream. Accepts one pixel per cycle unless a pooled result is held
// and not being taken downstream.
module maxpool2x2_stream
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
  parameter int ROWS            = 4,
  parameter int COLS            = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int W     = PIXEL_BIT_WIDTH;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int BUF_N = COLS / 2;
  localparam int IW    = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  if ((ROWS % 2) != 0 || ROWS < 2) begin : g_bad_rows
    $error("maxpool2x2_stream: ROWS must be even and >= 2");
  end
  if ((COLS % 2) != 0 || COLS < 2) begin : g_bad_cols
    $error("maxpool2x2_stream: COLS must be even and >= 2");
  end
  if (W > MAX_PIXEL_W || W < 1) begin : g_bad_width
    $error("maxpool2x2_stream: PIXEL_BIT_WIDTH out of range");
  end

  function automatic logic [W-1:0] pmax(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(signed_max(MAX_PIXEL_W'($signed(a)), MAX_PIXEL_W'($signed(b))));
  endfunction

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [W-1:0]  hold;
  logic          accept;
  logic          last_col, last_row;
  logic [IW-1:0] buf_idx;
  logic [W-1:0]  buf_rd;
  logic [W-1:0]  pair_max;   // max(hold, pixel_in)
  logic [W-1:0]  col_max;    // max(rowbuf, pixel_in)
  logic          buf_we;

  // Handshake, position decode and datapath maxima.
  always_comb begin
    in_ready = reset & (~out_valid | out_ready);
    accept   = in_valid & in_ready;
    last_col = (col == CW'(COLS - 1));
    last_row = (row == RW'(ROWS - 1));
    buf_idx  = IW'(col >> 1);
    pair_max = pmax(hold, pixel_in);
    col_max  = pmax(buf_rd, pixel_in);
    buf_we   = accept & ~row[0] & col[0];
  end

  maxpool_row_buffer #(
    .DEPTH (BUF_N),
    .WIDTH (W),
    .IW    (IW)
  ) u_rowbuf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_idx),
    .wdata (pair_max),
    .raddr (buf_idx),
    .rdata (buf_rd)
  );

  // Raster counters, hold register and output register. A drain and a
  // new load on the same edge keep out_valid high with the new result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row       <= '0;
      col       <= '0;
      hold      <= '0;
      pixel_out <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        case ({row[0], col[0]})
          2'b00:   hold <= pixel_in;
          2'b10:   hold <= col_max;
          2'b11: begin
            pixel_out <= pair_max;
            out_valid <= 1'b1;
            out_last  <= last_row & last_col;
          end
          default: ;  // even row, odd col: row buffer write only
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench: three pooling instances (6x6, 4x4, 2x2) share one
// stimulus/response port set selected by sel; expected pooled pixels are
// queued as stimulus is launched and popped as outputs are taken.
module tb_maxpool2x2_stream;
  import crop_pkg::*;

  typedef struct packed {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sel;
  logic [7:0] pix;
  logic       valid, ready;

  logic       in_rdy [3];
  logic       ov     [3];
  logic       ol     [3];
  logic [7:0] po     [3];

  logic       in_ready, out_valid, out_last;
  logic [7:0] pixel_out;

  exp_t       expq  [$];
  logic [7:0] frame [$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  maxpool2x2_stream #(.PIXEL_BIT_WIDTH(8), .ROWS(6), .COLS(6)) dut6 (
    .clk(clk), .reset(reset), .pixel_in(pix), .in_valid(valid && sel == 2'd0),
    .in_ready(in_rdy[0]), .pixel_out(po[0]), .out_valid(ov[0]),
    .out_ready(ready && sel == 2'd0), .out_last(ol[0]));

  maxpool2x2_stream #(.PIXEL_BIT_WIDTH(8), .ROWS(4), .COLS(4)) dut4 (
    .clk(clk), .reset(reset), .pixel_in(pix), .in_valid(valid && sel == 2'd1),
    .in_ready(in_rdy[1]), .pixel_out(po[1]), .out_valid(ov[1]),
    .out_ready(ready && sel == 2'd1), .out_last(ol[1]));

  maxpool2x2_stream #(.PIXEL_BIT_WIDTH(8), .ROWS(2), .COLS(2)) dut2 (
    .clk(clk), .reset(reset), .pixel_in(pix), .in_valid(valid && sel == 2'd2),
    .in_ready(in_rdy[2]), .pixel_out(po[2]), .out_valid(ov[2]),
    .out_ready(ready && sel == 2'd2), .out_last(ol[2]));

  always_comb begin
    in_ready  = in_rdy[sel];
    out_valid = ov[sel];
    out_last  = ol[sel];
    pixel_out = po[sel];
  end

  task automatic push_exp(input logic [7:0] v, input logic last);
    exp_t e;
    e.pix  = v;
    e.last = last;
    expq.push_back(e);
  endtask

  task automatic push_index6();
    push_exp(8'd7, 0);  push_exp(8'd9, 0);  push_exp(8'd11, 0);
    push_exp(8'd19, 0); push_exp(8'd21, 0); push_exp(8'd23, 0);
    push_exp(8'd31, 0); push_exp(8'd33, 0); push_exp(8'd35, 1);
  endtask

  task automatic fill_index(input int n, input int base);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(8'(base + i));
  endtask

  // Driver: offers frame pixels, optionally with random valid gaps.
  task automatic send(input bit rand_v);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < frame.size() && cyc < 5000) begin
      valid = rand_v ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix   = frame[idx];
      @(negedge clk);
      hs = valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    valid = 1'b0;
    if (idx < frame.size()) begin
      tests++; fails++;
      $display("FAIL send_timeout: accepted %0d of %0d pixels", idx, frame.size());
    end
  endtask

  // Collector: pops the scoreboard on every taken output and checks
  // stall behaviour whenever a result is held.
  task automatic collect(input int n, input bit rand_r);
    int   got = 0;
    int   cyc = 0;
    bit   stalled = 0;
    exp_t held, e, obs;
    while (got < n && cyc < 5000) begin
      ready = rand_r ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      obs.pix  = pixel_out;
      obs.last = out_last;
      if (stalled && out_valid) begin
        tests++;
        if (obs !== held) begin
          fails++;
          $display("FAIL stall_stable: got %h/%b need %h/%b", obs.pix, obs.last, held.pix, held.last);
        end
      end
      stalled = 0;
      if (out_valid && !ready) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_in_ready: got %b need 0", in_ready);
        end
        stalled = 1;
        held    = obs;
      end
      if (out_valid && ready) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL extra_output: got %h with empty scoreboard", obs.pix);
        end else begin
          e = expq.pop_front();
          if (obs !== e) begin
            fails++;
            $display("FAIL pooled_out: got %h last=%b need %h last=%b", obs.pix, obs.last, e.pix, e.last);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ready = 1'b1;
    if (got < n) begin
      tests++; fails++;
      $display("FAIL collect_timeout: got %0d of %0d outputs", got, n);
    end
  endtask

  task automatic run_stream(input bit rand_v, input bit rand_r);
    int n;
    n = expq.size();
    fork
      send(rand_v);
      collect(n, rand_r);
    join
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || expq.size() != 0) begin
      fails++;
      $display("FAIL drained: out_valid=%b pending=%0d need 0/0", out_valid, expq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 1'b0; ready = 1'b0; pix = '0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({out_valid, out_last, pixel_out, in_ready} !== 11'b0) begin
      fails++;
      $display("FAIL reset_state6: got v=%b l=%b p=%h rdy=%b need all 0", out_valid, out_last, pixel_out, in_ready);
    end
    tests++;
    if ({ov[1], ov[2], in_rdy[1], in_rdy[2], po[1], po[2]} !== 20'b0) begin
      fails++;
      $display("FAIL reset_state42: got v4=%b v2=%b r4=%b r2=%b need 0", ov[1], ov[2], in_rdy[1], in_rdy[2]);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b need 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_index();
    sel = 2'd0;
    fill_index(36, 0);
    push_index6();
    run_stream(0, 0);
  endtask

  task automatic test_signed();
    sel = 2'd2;
    frame = '{8'hFB, 8'h80, 8'hFF, 8'hFE};
    push_exp(8'hFF, 1);
    run_stream(0, 0);
    frame = '{8'h80, 8'h80, 8'h80, 8'h80};
    push_exp(8'h80, 1);
    run_stream(0, 0);
    frame = '{8'h7F, 8'h80, 8'h00, 8'h81};
    push_exp(8'h7F, 1);
    run_stream(0, 0);
  endtask

  task automatic test_random();
    sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      fill_index(36, 0);
      push_index6();
      run_stream(1, 1);
    end
  endtask

  task automatic test_back_to_back();
    sel = 2'd1;
    fill_index(16, 0);
    for (int i = 0; i < 16; i++) frame.push_back(8'(100 + i));
    push_exp(8'd5, 0);   push_exp(8'd7, 0);   push_exp(8'd13, 0);  push_exp(8'd15, 1);
    push_exp(8'd105, 0); push_exp(8'd107, 0); push_exp(8'd113, 0); push_exp(8'd115, 1);
    run_stream(0, 0);
  endtask

  task automatic test_reset_midframe();
    int idx = 0;
    bit hs;
    sel   = 2'd0;
    ready = 1'b0;
    fill_index(10, 0);
    for (int c = 0; c < 10; c++) begin
      valid = 1'b1;
      pix   = frame[idx];
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      if (hs && idx < 9) idx++;
    end
    valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL pending_before_reset: got v=%b rdy=%b need 1/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL in_ready_in_reset: got %b need 0", in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, out_last, pixel_out} !== 10'b0) begin
      fails++;
      $display("FAIL after_reset: got v=%b l=%b p=%h need 0", out_valid, out_last, pixel_out);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    fill_index(36, 0);
    push_index6();
    run_stream(0, 0);
  endtask

  initial begin
    test_reset();
    test_index();
    test_signed();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
